hack_boot_loader: RTL and testbench
===================================

Name: hack_boot_loader

Overview:
- Sequences HACK CPU start-up: holds the CPU in reset, receives a program image over a byte stream, writes it word-by-word into instruction ROM, verifies a checksum, then releases CPU reset.
- Sits between the host/UART byte receiver and the ROM write port plus the CPU `reset` input.
- The CPU and its synchronous ROM read path are unchanged; this block owns ROM writes and CPU reset only.

Parameters:
- ADDR_W, 15, ROM word-address width (matches CPU `pc`).
- MAX_WORDS, 16384, largest accepted image in words.
- RESET_HOLD, 2, cycles the CPU reset stays asserted after a successful load (minimum 1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  incoming image byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block can accept a byte; transfer occurs when rx_valid && rx_ready at posedge.
- reload  in  1  single-cycle request to reload a new image; honoured only in RUN or ERROR.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_waddr  out  ADDR_W  ROM write address.
- rom_wdata  out  16  ROM write data.
- cpu_reset  out  1  active-high reset to the HACK CPU.
- busy  out  1  high in any load/hold state.
- done  out  1  high in RUN.
- error  out  1  high in ERROR.
- words_loaded  out  ADDR_W+1  words written in the current/last load.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on reset_n. Every flop clears on reset_n low, independent of clk.
- Image format, big-endian: CNT_HI, CNT_LO (word count N, 16 bits), then N words as HI byte then LO byte, then one checksum byte. The checksum is the XOR of all 2N payload bytes.
- Reset values: state=CNT_HI, cpu_reset=1, rx_ready=0, rom_we=0, rom_waddr=0, rom_wdata=0, busy=1, done=0, error=0, words_loaded=0, xor accumulator=0.
- rx_ready is registered. It is 1 in CNT_HI, CNT_LO, DATA_HI, DATA_LO and CSUM, and 0 elsewhere. The first cycle after reset deasserts, it is still 0.
- State transitions, each on an accepted byte unless stated otherwise:
  - CNT_HI -> CNT_LO.
  - CNT_LO: if N==0 -> CSUM. If N>MAX_WORDS -> ERROR. Otherwise -> DATA_HI.
  - DATA_HI: latch the high byte -> DATA_LO.
  - DATA_LO: on the cycle after accept, drive rom_we=1 for exactly one cycle with rom_wdata={hi,lo} and rom_waddr=current index. The index increments after the write. words_loaded increments with each write. After word N-1 -> CSUM, otherwise -> DATA_HI.
  - CSUM: if byte==accumulator -> HOLD, otherwise -> ERROR.
  - HOLD: no byte needed. Counts RESET_HOLD cycles with cpu_reset=1, then -> RUN.
  - RUN: cpu_reset=0, done=1, busy=0.
  - ERROR: cpu_reset=1, error=1, busy=0, rx_ready=0. The block stays here until reload or reset.
- reload asserted in RUN or ERROR resets the following on the next cycle: state=CNT_HI, cpu_reset=1 (the CPU is held in reset from that edge), index=0, words_loaded=0, accumulator=0, done=0, error=0. reload in any other state is ignored.
- Address wrap: the index never exceeds MAX_WORDS-1 because N is bounded at CNT_LO. N==MAX_WORDS writes addresses 0..MAX_WORDS-1.
- rx_valid stalls (low) in any receive state: the block holds its state and asserts no rom_we.
- Back-to-back bytes: sustained one byte per cycle with no bubble. A rom_we pulse may coincide with the next DATA_HI accept.
- reset_n asserted mid-load aborts immediately. Partially written ROM content is undefined, and the CPU stays in reset.

Decomposition:
- Shared package holds: the state encoding enum (CNT_HI, CNT_LO, DATA_HI, DATA_LO, CSUM, HOLD, RUN, ERROR), the HACK ADDR_W=15 and word width 16 constants, and the image header byte count (2).
- One natural sub-module: hack_boot_hold_counter, the RESET_HOLD down-counter with load/expire. Everything else is a single FSM module.

Test Plan:
- Image N=3 with words 0x0002, 0xEC10, 0x0010, checksum 0x00^0x02^0xEC^0x10^0x00^0x10=0xEE, one byte per cycle: rom_we pulses at addresses 0,1,2 with those data; cpu_reset falls exactly RESET_HOLD cycles after the CSUM accept; done=1; words_loaded=3.
- Same image with checksum 0xEF: three ROM writes occur, then error=1, cpu_reset stays 1, rx_ready=0. A reload pulse returns the block to CNT_HI, after which a correct image reaches RUN.
- Header N=0x4001 with MAX_WORDS=16384: error=1 immediately after CNT_LO, and no rom_we ever.
- N=0 followed by checksum 0x00: no writes, RUN reached, words_loaded=0.
- Random rx_valid gaps during the N=3 image: identical ROM writes and final state, and exactly one rom_we per word.
- reset_n pulled low after the second word: all outputs return to their reset values asynchronously (cpu_reset=1, rom_we=0). A full reload after release succeeds.

Source files
------------

// File: rtl/hack_boot_loader_pkg.sv
// HACK boot loader shared types and constants.
package hack_boot_loader_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_WORD_W = 16;
  localparam int HDR_BYTES   = 2;

  typedef enum logic [2:0] {
    ST_CNT_HI  = 3'd0,
    ST_CNT_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_CSUM    = 3'd4,
    ST_HOLD    = 3'd5,
    ST_RUN     = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

endpackage

// File: rtl/hack_boot_hold_counter.sv
// CPU reset hold timer: load on good checksum,
// expires after HOLD enabled cycles.
module hack_boot_hold_counter #(
  parameter int HOLD = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(HOLD - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/hack_boot_loader.sv
// HACK boot loader: receives a byte-stream image,
// writes instruction ROM, verifies XOR checksum, releases CPU.
module hack_boot_loader
  import hack_boot_loader_pkg::*;
#(
  parameter int ADDR_W     = HACK_ADDR_W,
  parameter int MAX_WORDS  = 16384,
  parameter int RESET_HOLD = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   reload,
  output logic                   rom_we,
  output logic [ADDR_W-1:0]      rom_waddr,
  output logic [HACK_WORD_W-1:0] rom_wdata,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_W:0]        words_loaded
);

  state_e state, state_nx;

  logic [7:0]  cnt_hi;
  logic [7:0]  hi;
  logic [7:0]  csum;
  logic [15:0] cnt;
  logic [15:0] n_rx;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   idx_inc;

  logic acc;
  logic last;
  logic reload_ok;
  logic hold_load;
  logic hold_exp;

  assign acc       = rx_valid && rx_ready;
  assign n_rx      = {cnt_hi, rx_data};
  assign idx_inc   = {1'b0, idx} + 1'b1;
  assign last      = (32'(idx_inc) == 32'(cnt));
  assign reload_ok = reload &&
                     (state == ST_RUN || state == ST_ERROR);

  hack_boot_hold_counter #(
    .HOLD(RESET_HOLD)
  ) u_hold (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (hold_load),
    .en     (state == ST_HOLD),
    .expired(hold_exp)
  );

  always_comb begin
    state_nx  = state;
    hold_load = 1'b0;
    unique case (state)
      ST_CNT_HI:
        if (acc) state_nx = ST_CNT_LO;
      ST_CNT_LO:
        if (acc) begin
          if (n_rx == '0)
            state_nx = ST_CSUM;
          else if (32'(n_rx) > 32'(MAX_WORDS))
            state_nx = ST_ERROR;
          else
            state_nx = ST_DATA_HI;
        end
      ST_DATA_HI:
        if (acc) state_nx = ST_DATA_LO;
      ST_DATA_LO:
        if (acc) state_nx = last ? ST_CSUM : ST_DATA_HI;
      ST_CSUM:
        if (acc) begin
          if (rx_data == csum) begin
            state_nx  = ST_HOLD;
            hold_load = 1'b1;
          end else begin
            state_nx = ST_ERROR;
          end
        end
      ST_HOLD:
        if (hold_exp) state_nx = ST_RUN;
      ST_RUN, ST_ERROR:
        if (reload) state_nx = ST_CNT_HI;
      default:
        state_nx = ST_CNT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_CNT_HI;
      rx_ready     <= 1'b0;
      rom_we       <= 1'b0;
      rom_waddr    <= '0;
      rom_wdata    <= '0;
      words_loaded <= '0;
      cnt_hi       <= '0;
      hi           <= '0;
      csum         <= '0;
      cnt          <= '0;
      idx          <= '0;
    end else begin
      state    <= state_nx;
      rx_ready <= (state_nx inside {ST_CNT_HI, ST_CNT_LO,
                   ST_DATA_HI, ST_DATA_LO, ST_CSUM});
      rom_we   <= 1'b0;
      if (acc) begin
        case (state)
          ST_CNT_HI: cnt_hi <= rx_data;
          ST_CNT_LO: cnt    <= n_rx;
          ST_DATA_HI: begin
            hi   <= rx_data;
            csum <= csum ^ rx_data;
          end
          ST_DATA_LO: begin
            rom_we       <= 1'b1;
            rom_waddr    <= idx;
            rom_wdata    <= {hi, rx_data};
            idx          <= idx + 1'b1;
            words_loaded <= words_loaded + 1'b1;
            csum         <= csum ^ rx_data;
          end
          default: ;
        endcase
      end
      if (reload_ok) begin
        idx          <= '0;
        words_loaded <= '0;
        csum         <= '0;
      end
    end
  end

  // Status decodes straight from the state flop.
  assign cpu_reset = (state != ST_RUN);
  assign busy      = (state != ST_RUN) && (state != ST_ERROR);
  assign done      = (state == ST_RUN);
  assign error     = (state == ST_ERROR);

endmodule

// File: tb/tb_hack_boot_loader.sv
// Scoreboard bench for hack_boot_loader.
module tb_hack_boot_loader;

  localparam int AW   = 15;
  localparam int HOLD = 2;

  logic          clk;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          reload;
  logic          rom_we;
  logic [AW-1:0] rom_waddr;
  logic [15:0]   rom_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  hack_boot_loader #(
    .ADDR_W    (AW),
    .MAX_WORDS (16384),
    .RESET_HOLD(HOLD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .reload      (reload),
    .rom_we      (rom_we),
    .rom_waddr   (rom_waddr),
    .rom_wdata   (rom_wdata),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int wr0;
  logic [15:0] img [3];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (reset_n && rom_we) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("waddr", 32'(rom_waddr), 32'(e.a));
        check("wdata", 32'(rom_wdata), 32'(e.d));
      end
    end
  end

  function automatic int rg(input int g);
    return (g == 0) ? 0 : int'($urandom_range(0, g));
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_img(input logic [15:0] n,
                          input logic [7:0] cs,
                          input int gap);
    send(n[15:8], rg(gap));
    send(n[7:0], rg(gap));
    for (int i = 0; i < int'(n); i++) begin
      sb.push_back('{a: AW'(i), d: img[i]});
      send(img[i][15:8], rg(gap));
      send(img[i][7:0], rg(gap));
    end
    send(cs, rg(gap));
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic wait_hold_and_run(input string tag,
                                   input int nw);
    check({tag, "_hold_rst"}, 32'(cpu_reset), 32'd1);
    repeat (HOLD - 1) begin @(posedge clk); #1; end
    check({tag, "_hold_last"}, 32'(cpu_reset), 32'd1);
    @(posedge clk); #1;
    check({tag, "_cpu_rst"}, 32'(cpu_reset), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wl"}, 32'(words_loaded), 32'(nw));
    check({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(nw));
    check({tag, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    img[0] = 16'h0002;
    img[1] = 16'hEC10;
    img[2] = 16'h0010;
    reset_n  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_rom_we", 32'(rom_we), 32'd0);
    check("rst_waddr", 32'(rom_waddr), 32'd0);
    check("rst_wdata", 32'(rom_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_wl", 32'(words_loaded), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rdy_first_cycle", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    check("rdy_cnt_hi", 32'(rx_ready), 32'd1);

    // good image, back-to-back bytes
    wr0 = wr_cnt;
    send_img(16'd3, 8'hEE, 0);
    check("t1_busy_hold", 32'(busy), 32'd1);
    wait_hold_and_run("t1", 3);

    // bad checksum, then reload and recover
    pulse_reload();
    check("rl_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rl_done", 32'(done), 32'd0);
    check("rl_wl", 32'(words_loaded), 32'd0);
    wr0 = wr_cnt;
    send_img(16'd3, 8'hEF, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("t2_error", 32'(error), 32'd1);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t2_rx_ready", 32'(rx_ready), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_nwr", 32'(wr_cnt - wr0), 32'd3);
    pulse_reload();
    check("t2_rl_error", 32'(error), 32'd0);
    wr0 = wr_cnt;
    send_img(16'd3, 8'hEE, 0);
    wait_hold_and_run("t2b", 3);

    // oversize header
    pulse_reload();
    wr0 = wr_cnt;
    send(8'h40, 0);
    send(8'h01, 0);
    rx_valid = 1'b0;
    check("t3_error", 32'(error), 32'd1);
    check("t3_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("t3_nwr", 32'(wr_cnt - wr0), 32'd0);

    // largest legal header is accepted
    pulse_reload();
    send(8'h40, 0);
    send(8'h00, 0);
    rx_valid = 1'b0;
    check("t3b_error", 32'(error), 32'd0);
    check("t3b_busy", 32'(busy), 32'd1);
    check("t3b_rx_ready", 32'(rx_ready), 32'd1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // empty image
    wr0 = wr_cnt;
    send_img(16'd0, 8'h00, 0);
    wait_hold_and_run("t4", 0);

    // random rx_valid gaps
    pulse_reload();
    wr0 = wr_cnt;
    send_img(16'd3, 8'hEE, 3);
    wait_hold_and_run("t5", 3);

    // reset mid-load after the second word
    pulse_reload();
    wr0 = wr_cnt;
    sb.push_back('{a: AW'(0), d: img[0]});
    sb.push_back('{a: AW'(1), d: img[1]});
    send(8'h00, 0);
    send(8'h03, 0);
    for (int i = 0; i < 2; i++) begin
      send(img[i][15:8], 0);
      send(img[i][7:0], 0);
    end
    rx_valid = 1'b0;
    @(negedge clk); #1;
    check("t6_nwr", 32'(wr_cnt - wr0), 32'd2);
    reset_n = 1'b0;
    #1;
    check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t6_rom_we", 32'(rom_we), 32'd0);
    check("t6_rx_ready", 32'(rx_ready), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_wl", 32'(words_loaded), 32'd0);
    check("t6_waddr", 32'(rom_waddr), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wr0 = wr_cnt;
    send_img(16'd3, 8'hEE, 1);
    wait_hold_and_run("t6b", 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
